// File: rtl/cs_accum32_seq.sv
// cs_accum32_seq: burst accumulator built around a 32-bit carry-select adder.
// A burst of len operands is taken over a valid/ready stream.
// Each accepted operand goes through an input register stage and is then
// added into acc_q. The total and a sticky unsigned-overflow flag are
// presented on a valid/ready result port.
// Optional feature macro: ACCUM_SATURATE_EN. When it is defined, an add with
// carry-out clamps acc_q to 32'hFFFF_FFFF instead of wrapping.

// 32-bit carry-select adder built from four 8-bit blocks.
// Block 0 ripples from cin. Each upper block precomputes its sum for both
// possible carry-ins and picks one with the incoming carry.
module cs_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);

  logic [8:0] blk0;
  logic [8:0] blk1_c0, blk1_c1;
  logic [8:0] blk2_c0, blk2_c1;
  logic [7:0] blk3_c0, blk3_c1;
  logic       c8, c16, c24;

  assign blk0    = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
  assign c8      = blk0[8];

  assign blk1_c0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign blk1_c1 = blk1_c0 + 9'd1;
  assign c16     = c8 ? blk1_c1[8] : blk1_c0[8];

  assign blk2_c0 = {1'b0, a[23:16]} + {1'b0, b[23:16]};
  assign blk2_c1 = blk2_c0 + 9'd1;
  assign c24     = c16 ? blk2_c1[8] : blk2_c0[8];

  // The top block has no carry-out; callers that need one derive it.
  assign blk3_c0 = a[31:24] + b[31:24];
  assign blk3_c1 = blk3_c0 + 8'd1;

  assign sum[7:0]   = blk0[7:0];
  assign sum[15:8]  = c8  ? blk1_c1[7:0] : blk1_c0[7:0];
  assign sum[23:16] = c16 ? blk2_c1[7:0] : blk2_c0[7:0];
  assign sum[31:24] = c24 ? blk3_c1     : blk3_c0;

endmodule

module cs_accum32_seq #(
  parameter int          LEN_W    = 8,
  parameter logic [31:0] INIT_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] rem_q;
  logic [31:0]      op_q;
  logic             op_v_q;
  logic             op_last_q;
  logic [31:0]      acc_q;
  logic             ovf_q;

  logic             in_fire;
  logic [31:0]      add_sum;
  logic             add_cout;
  logic [31:0]      acc_next;

  // Stage-2 adder: the running sum plus the registered operand.
  cs_adder32 u_adder (
    .a   (acc_q),
    .b   (op_q),
    .cin (1'b0),
    .sum (add_sum)
  );

  // Unsigned carry-out recovered from the operand and sum MSBs.
  assign add_cout = (acc_q[31] & op_q[31]) | ((acc_q[31] | op_q[31]) & ~add_sum[31]);

`ifdef ACCUM_SATURATE_EN
  // Clamp on overflow. Any later add to all-ones also carries, so the clamp holds.
  assign acc_next = add_cout ? 32'hFFFF_FFFF : add_sum;
`else
  assign acc_next = add_sum;
`endif

  // in_ready is decoded from state alone, so it never waits on in_valid.
  assign in_ready  = (state == ACCUM);
  assign in_fire   = in_valid & in_ready;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = (state == DONE) ? acc_q : 32'd0;
  assign out_ovf   = (state == DONE) ? ovf_q : 1'b0;

  // Control FSM, input register stage and accumulate stage.
  // NOTE: every register here uses <= so that all of them update from
  // pre-edge values. A later case arm may therefore override an earlier
  // default in the same block without any ordering hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: op_q and op_last_q are reset even though op_v_q already marks
      // them invalid. This keeps the datapath free of X after reset.
      state     <= IDLE;
      rem_q     <= '0;
      op_q      <= 32'd0;
      op_v_q    <= 1'b0;
      op_last_q <= 1'b0;
      acc_q     <= INIT_VAL;
      ovf_q     <= 1'b0;
    end else begin
      // Stage 1: capture an accepted beat; the valid bit drops on idle cycles.
      op_v_q <= in_fire;
      if (in_fire) begin
        op_q      <= in_data;
        op_last_q <= (rem_q == LEN_W'(1));
        rem_q     <= rem_q - LEN_W'(1);
      end

      // Stage 2: fold the registered operand into the running sum.
      if (op_v_q) begin
        acc_q <= acc_next;
        ovf_q <= ovf_q | add_cout;
      end

      case (state)
        IDLE: begin
          if (start) begin
            acc_q <= INIT_VAL;
            ovf_q <= 1'b0;
            if (len != '0) begin
              rem_q <= len;
              state <= ACCUM;
            end else begin
              state <= DONE;
            end
          end
        end
        ACCUM: begin
          if (in_fire && (rem_q == LEN_W'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (op_v_q && op_last_q) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_accum32_seq.sv
// Self-checking bench for cs_accum32_seq using directed vectors and a small
// reference model. Build with +define+ACCUM_SATURATE_EN to check the clamping
// variant.
`timescale 1ns/1ps

module tb_cs_accum32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_ovf;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] data_q [0:255];

  cs_accum32_seq #(.LEN_W(8), .INIT_VAL(32'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: unsigned 33-bit accumulation of the first n beats.
  task automatic model(input int n, output logic [31:0] sum, output logic ovf);
    logic [32:0] t;
    sum = 32'd0;
    ovf = 1'b0;
    for (int k = 0; k < n; k++) begin
      t = {1'b0, sum} + {1'b0, data_q[k]};
`ifdef ACCUM_SATURATE_EN
      sum = t[32] ? 32'hFFFF_FFFF : t[31:0];
`else
      sum = t[31:0];
`endif
      ovf = ovf | t[32];
    end
  endtask

  // Runs one burst of n beats from data_q with random gaps. The result is
  // then held unaccepted for 'hold' cycles before it is accepted.
  // With poke set, start is pulsed during ACCUM, during DONE and on the
  // accept cycle; each of those pulses must be ignored.
  task automatic run_burst(input string tag, input int n, input int gap_pct, input int hold,
                           input bit poke, input logic [31:0] exp_sum, input logic exp_ovf);
    int i;
    int guard;
    int lat;
    @(negedge clk);
    start = 1'b1;
    len   = n[7:0];
    @(negedge clk);
    start = 1'b0;
    i     = 0;
    guard = 0;
    while (i < n && guard < 8 * n + 50) begin
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = data_q[i];
      end
      start = poke && (i == 1);
      len   = 8'd9;
      // The transfer happens at the next rising edge.
      if (in_valid && in_ready) i++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check({tag, "_beats"}, i, n);
    lat = 0;
    while (!out_valid && lat < 3) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    for (int h = 0; h < hold; h++) begin
      start = poke && (h == 0);
      @(negedge clk);
      start = 1'b0;
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_sum"}, out_sum, exp_sum);
    end
    check({tag, "_sum"}, out_sum, exp_sum);
    check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, exp_ovf});
    out_ready = 1'b1;
    start     = poke;
    len       = 8'd3;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] m_sum;
    logic        m_ovf;
    int          n;

    rst       = 1'b1;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    rst = 1'b0;

    // Reset in the middle of a burst: start len=5, send 3 beats, then reset.
    @(negedge clk);
    start = 1'b1;
    len   = 8'd5;
    @(negedge clk);
    start = 1'b0;
    check("mid_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'd100 + k;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    data_q[0] = 32'd7;
    run_burst("after_rst", 1, 0, 0, 1'b0, 32'd7, 1'b0);

    // Basic back-to-back burst: 1+2+3+4 = 10.
    data_q[0] = 32'd1; data_q[1] = 32'd2; data_q[2] = 32'd3; data_q[3] = 32'd4;
    run_burst("basic", 4, 0, 0, 1'b0, 32'd10, 1'b0);

    // Gaps on in_valid and 5 cycles of out_ready low: 0x10+0x20+0x30 = 0x60.
    data_q[0] = 32'h10; data_q[1] = 32'h20; data_q[2] = 32'h30;
    run_burst("gaps", 3, 50, 5, 1'b0, 32'h60, 1'b0);

    // Wrap past 2^32: 0xFFFFFFFF + 2.
    data_q[0] = 32'hFFFF_FFFF; data_q[1] = 32'h0000_0002;
`ifdef ACCUM_SATURATE_EN
    run_burst("wrap", 2, 0, 1, 1'b0, 32'hFFFF_FFFF, 1'b1);
`else
    run_burst("wrap", 2, 0, 1, 1'b0, 32'h0000_0001, 1'b1);
`endif

    // Zero-length burst goes straight to DONE with INIT_VAL.
    run_burst("len0", 0, 0, 2, 1'b0, 32'd0, 1'b0);

    // Start pulses during ACCUM, DONE and the accept cycle are ignored.
    data_q[0] = 32'd5; data_q[1] = 32'd6; data_q[2] = 32'd8;
    run_burst("ign_start", 3, 0, 3, 1'b1, 32'd19, 1'b0);

    // Random bursts checked against the model.
    for (int b = 0; b < 30; b++) begin
      n = $urandom_range(255, 1);
      for (int k = 0; k < n; k++) data_q[k] = $urandom;
      model(n, m_sum, m_ovf);
      run_burst("rand", n, 30, $urandom_range(3), 1'b0, m_sum, m_ovf);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
